// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller.
// One transaction in flight; commands latched at grant.
module psram_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDRESS_BITS = 23,
  parameter int DATA_BITS    = 16,
  parameter int RD_LATENCY   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
  input  logic [NUM_PORTS*DATA_BITS-1:0]    req_wr_data,
  output logic [NUM_PORTS-1:0]              req_ack,
  output logic [NUM_PORTS-1:0]              rd_valid,
  output logic [DATA_BITS-1:0]              rd_data,
  output logic                              busy,
  output logic                              mem_rd_en,
  output logic [ADDRESS_BITS-1:0]           mem_rd_address,
  input  logic                              mem_rd_ack,
  input  logic [DATA_BITS-1:0]              mem_rd_data,
  output logic                              mem_wr_en,
  output logic [ADDRESS_BITS-1:0]           mem_wr_address,
  output logic [DATA_BITS-1:0]              mem_wr_data,
  input  logic                              mem_wr_ack
);

  localparam int PORT_BITS = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int LAT_BITS  = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_RD,
    ISSUE_WR,
    WAIT_RD
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PORT_BITS-1:0]    rr_ptr;
  logic [PORT_BITS-1:0]    grant;
  logic [PORT_BITS-1:0]    gnt;
  logic                    hit;
  logic [LAT_BITS-1:0]     lat_cnt;
  logic                    lat_done;
  logic [ADDRESS_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0]    cmd_data;
  int unsigned             idx;

  assign lat_done = (state == WAIT_RD) &&
                    (lat_cnt == LAT_BITS'(RD_LATENCY - 1));

  // Rotating priority search starting at rr_ptr
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        gnt = PORT_BITS'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (hit) state_nxt = req_we[gnt] ? ISSUE_WR : ISSUE_RD;
      ISSUE_WR:
        if (mem_wr_ack) state_nxt = IDLE;
      ISSUE_RD:
        if (mem_rd_ack) state_nxt = WAIT_RD;
      WAIT_RD:
        if (lat_done) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and the live arbitration result
  always_comb begin
    req_ack   = '0;
    mem_rd_en = (state == ISSUE_RD);
    mem_wr_en = (state == ISSUE_WR);
    busy      = (state != IDLE);
    if (state == IDLE && hit && !reset) req_ack[gnt] = 1'b1;
  end

  assign mem_rd_address = cmd_addr;
  assign mem_wr_address = cmd_addr;
  assign mem_wr_data    = cmd_data;

  // Command capture, pointer rotation, latency count and read return
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant    <= '0;
      lat_cnt  <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (state == IDLE && hit) begin
        cmd_addr <= req_address[gnt*ADDRESS_BITS +: ADDRESS_BITS];
        cmd_data <= req_wr_data[gnt*DATA_BITS +: DATA_BITS];
        grant    <= gnt;
        rr_ptr   <= (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + 1'b1;
      end
      if (state == ISSUE_RD && mem_rd_ack) lat_cnt <= '0;
      else if (state == WAIT_RD)           lat_cnt <= lat_cnt + 1'b1;
      if (lat_done) begin
        rd_data         <= mem_rd_data;
        rd_valid[grant] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a PSRAM
// controller model and a read-return scoreboard.
module tb_psram_arbiter;

  localparam int NP  = 4;
  localparam int AB  = 23;
  localparam int DB  = 16;
  localparam int RDL = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NP-1:0]  req, req_we, hold, a_last;
  logic [NP*AB-1:0] req_address;
  logic [NP*DB-1:0] req_wr_data;
  logic [NP-1:0]  req_ack, rd_valid;
  logic [DB-1:0]  rd_data, mem_rd_data, mem_wr_data;
  logic           busy, mem_rd_en, mem_rd_ack;
  logic           mem_wr_en, mem_wr_ack;
  logic           stall_rd, stall_wr;
  logic [AB-1:0]  mem_rd_address, mem_wr_address;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            port;
    logic [DB-1:0] data;
  } rd_exp_t;

  rd_exp_t       rdq[$];
  logic [DB-1:0] refmem[logic [AB-1:0]];

  logic [DB-1:0] cmem[256];
  logic [AB:0]   ctag[256];
  logic [DB-1:0] pipe[RDL];

  always #5 clk = ~clk;

  psram_arbiter #(
    .NUM_PORTS(NP), .ADDRESS_BITS(AB),
    .DATA_BITS(DB), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we),
    .req_address(req_address),
    .req_wr_data(req_wr_data),
    .req_ack(req_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy),
    .mem_rd_en(mem_rd_en),
    .mem_rd_address(mem_rd_address),
    .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_address(mem_wr_address),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack)
  );

  function automatic logic [DB-1:0] dflt(logic [AB-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DB-1:0] crd(logic [AB-1:0] a);
    if (ctag[a[7:0]] === {1'b1, a}) return cmem[a[7:0]];
    return dflt(a);
  endfunction

  function automatic logic [DB-1:0] ref_rd(logic [AB-1:0] a);
    if (refmem.exists(a)) return refmem[a];
    return dflt(a);
  endfunction

  // Controller model: ack when not stalled, fixed read latency
  assign mem_rd_ack  = mem_rd_en & ~stall_rd;
  assign mem_wr_ack  = mem_wr_en & ~stall_wr;
  assign mem_rd_data = pipe[RDL-1];

  always @(posedge clk) begin
    for (int k = RDL - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (mem_rd_en && mem_rd_ack) ? crd(mem_rd_address) : 16'hDEAD;
    if (mem_wr_en && mem_wr_ack) begin
      cmem[mem_wr_address[7:0]] <= mem_wr_data;
      ctag[mem_wr_address[7:0]] <= {1'b1, mem_wr_address};
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge and run the scoreboard
  task automatic smp();
    rd_exp_t e;
    logic [AB-1:0] a;
    @(negedge clk);
    a_last = req_ack;
    if (reset) begin
      rdq.delete();
    end else begin
      if (rd_valid != '0) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 64'(rd_valid), 64'd0);
        end else begin
          e = rdq.pop_front();
          chk("rd_port", 64'(rd_valid), 64'(1 << e.port));
          chk("rd_data", 64'(rd_data), 64'(e.data));
        end
      end
      if (req_ack != '0) begin
        chk("ack_onehot", 64'($onehot(req_ack)), 64'd1);
        for (int q = 0; q < NP; q++) begin
          if (req_ack[q]) begin
            a = req_address[q*AB +: AB];
            if (req_we[q]) refmem[a] = req_wr_data[q*DB +: DB];
            else rdq.push_back('{port: q, data: ref_rd(a)});
          end
        end
      end
      if (mem_rd_en || mem_wr_en)
        chk("en_excl", 64'(mem_rd_en & mem_wr_en), 64'd0);
    end
  endtask

  // Step past posedge; acked requesters drop req unless holding
  task automatic adv();
    @(posedge clk);
    #1;
    req = req & ~(a_last & ~hold);
    a_last = '0;
  endtask

  task automatic issue(int p, logic we, logic [AB-1:0] a, logic [DB-1:0] d);
    req[p] = 1'b1;
    req_we[p] = we;
    req_address[p*AB +: AB] = a;
    req_wr_data[p*DB +: DB] = d;
  endtask

  task automatic wait_any(output int p, input string tag);
    p = -1;
    for (int n = 0; n < 40 && p < 0; n++) begin
      smp();
      for (int q = 0; q < NP; q++) if (req_ack[q]) p = q;
      if (p < 0) adv();
    end
    if (p < 0) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_idle(string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      smp();
      if (!busy) done = 1'b1;
      else adv();
    end
    if (!done) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    reset = 1'b1;
    req = '1;
    req_we = '0;
    hold = '0;
    a_last = '0;
    req_address = '0;
    req_wr_data = '0;
    stall_rd = 1'b0;
    stall_wr = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("rst_ack", 64'(req_ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rdv", 64'(rd_valid), 64'd0);
      chk("rst_rdd", 64'(rd_data), 64'd0);
      chk("rst_ens", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      adv();
    end
    reset = 1'b0;
    req = '0;

    // Round robin, all ports reading continuously
    for (int q = 0; q < NP; q++) issue(q, 1'b0, 23'h100 + 23'(q), '0);
    hold = '1;
    for (int g = 0; g < 5; g++) begin
      wait_any(p, "rr");
      chk("rr_order", 64'(p), 64'(g % NP));
      adv();
    end
    hold = '0;
    req = '0;
    wait_idle("rr_drain");
    adv();

    // Single write then read on port 1
    issue(1, 1'b1, 23'h12345, 16'hBEEF);
    smp();
    chk("wr_ack", 64'(req_ack), 64'b0010);
    adv();
    smp();
    chk("wr_en", 64'(mem_wr_en), 64'd1);
    chk("wr_addr", 64'(mem_wr_address), 64'h12345);
    chk("wr_data", 64'(mem_wr_data), 64'hBEEF);
    adv();
    issue(1, 1'b0, 23'h12345, '0);
    smp();
    chk("rd_ack", 64'(req_ack), 64'b0010);
    adv();
    for (int k = 1; k <= 5; k++) begin
      smp();
      if (k == 1) begin
        chk("rd_en", 64'(mem_rd_en), 64'd1);
        chk("rd_addr", 64'(mem_rd_address), 64'h12345);
      end
      if (k < 5) begin
        chk("rdv_early", 64'(rd_valid), 64'd0);
      end else begin
        chk("rdv_t5", 64'(rd_valid), 64'b0010);
        chk("rdd_t5", 64'(rd_data), 64'hBEEF);
      end
      adv();
    end

    // Contention with rr_ptr = 2, req = 0b1011
    issue(0, 1'b0, 23'h200, '0);
    issue(1, 1'b0, 23'h201, '0);
    issue(3, 1'b0, 23'h203, '0);
    wait_any(p, "ct0");
    chk("ct_first", 64'(p), 64'd3);
    adv();
    wait_any(p, "ct1");
    chk("ct_second", 64'(p), 64'd0);
    adv();
    wait_any(p, "ct2");
    chk("ct_third", 64'(p), 64'd1);
    adv();
    wait_idle("ct_drain");
    adv();

    // Back-pressure: read ack withheld for 10 cycles
    stall_rd = 1'b1;
    issue(2, 1'b0, 23'h00777, '0);
    smp();
    chk("bp_ack", 64'(req_ack), 64'b0100);
    adv();
    issue(0, 1'b0, 23'h300, '0);
    issue(3, 1'b0, 23'h303, '0);
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("bp_en", 64'(mem_rd_en), 64'd1);
      chk("bp_addr", 64'(mem_rd_address), 64'h00777);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_noack", 64'(req_ack), 64'd0);
      adv();
    end
    stall_rd = 1'b0;
    wait_any(p, "bp0");
    chk("bp_next", 64'(p), 64'd3);
    adv();
    wait_any(p, "bp1");
    chk("bp_after", 64'(p), 64'd0);
    adv();
    wait_idle("bp_drain");
    adv();

    // Read return overlapping a new grant
    issue(0, 1'b0, 23'h12345, '0);
    smp();
    chk("ov_ack0", 64'(req_ack), 64'b0001);
    adv();
    issue(2, 1'b1, 23'h0ABCD, 16'h1234);
    for (int k = 1; k <= 5; k++) begin
      smp();
      if (k < 5) begin
        chk("ov_wait", 64'(req_ack), 64'd0);
      end else begin
        chk("ov_rdv", 64'(rd_valid), 64'b0001);
        chk("ov_ack2", 64'(req_ack), 64'b0100);
        chk("ov_rdd", 64'(rd_data), 64'hBEEF);
      end
      adv();
    end
    req_address[2*AB +: AB] = 23'h7FFFF;
    req_wr_data[2*DB +: DB] = 16'hFFFF;
    smp();
    chk("ov_wen", 64'(mem_wr_en), 64'd1);
    chk("ov_waddr", 64'(mem_wr_address), 64'h0ABCD);
    chk("ov_wdata", 64'(mem_wr_data), 64'h1234);
    adv();
    issue(2, 1'b0, 23'h0ABCD, '0);
    wait_any(p, "ov_rb");
    chk("ov_rb_port", 64'(p), 64'd2);
    adv();
    wait_idle("ov_drain");
    adv();

    // Reset during WAIT_RD with lat_cnt = 1
    issue(1, 1'b0, 23'h0ABCD, '0);
    smp();
    chk("ra_ack", 64'(req_ack), 64'b0010);
    adv();
    smp();
    adv();
    smp();
    adv();
    reset = 1'b1;
    smp();
    chk("ra_busy", 64'(busy), 64'd1);
    adv();
    smp();
    chk("ra_idle", 64'(busy), 64'd0);
    chk("ra_rden", 64'(mem_rd_en), 64'd0);
    chk("ra_rdv", 64'(rd_valid), 64'd0);
    adv();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("ra_norv", 64'(rd_valid), 64'd0);
      adv();
    end
    issue(0, 1'b0, 23'h12345, '0);
    issue(3, 1'b0, 23'h0ABCD, '0);
    wait_any(p, "ra_new");
    chk("ra_ptr0", 64'(p), 64'd0);
    adv();
    for (int k = 1; k <= 5; k++) begin
      smp();
      if (k == 5) begin
        chk("ra_rdv0", 64'(rd_valid), 64'b0001);
        chk("ra_rdd0", 64'(rd_data), 64'hBEEF);
      end
      adv();
    end
    wait_idle("ra_drain");
    adv();

    chk("sb_empty", 64'(rdq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Round-robin arbiter that shares one async PSRAM controller (split rd/wr request ports, same-cycle ack while idle, fixed read latency) between NUM_PORTS requesters. Sits between core-side clients (CPU, video fetch, APF bridge loader, ...) and the PSRAM controller. Keeps exactly one transaction in flight, latches each requester's command on grant, and returns read data with a per-port valid pulse.

## Interface
Parameters:
- NUM_PORTS, 4: number of requesters, 2..8.
- ADDRESS_BITS, 23: word address width, both banks included; matches the controller.
- DATA_BITS, 16: data width.
- RD_LATENCY, 3: cycles from the cycle `mem_rd_ack` is high to the cycle `mem_rd_data` is valid, ≥1. For the controller, this equals its ceil(RAM_CYCLE_NANOS/clock period) cycle count, minimum 3.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request, level.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_address  in  NUM_PORTS*ADDRESS_BITS  port p is at [p*ADDRESS_BITS +: ADDRESS_BITS].
- req_wr_data  in  NUM_PORTS*DATA_BITS  port p is at [p*DATA_BITS +: DATA_BITS].
- req_ack  out  NUM_PORTS  one-hot, combinational; command accepted this cycle.
- rd_valid  out  NUM_PORTS  one-hot registered pulse; rd_data belongs to this port.
- rd_data  out  DATA_BITS  shared read data, registered, holds until the next read return.
- busy  out  1  high whenever state ≠ IDLE.
- mem_rd_en, mem_rd_address (ADDRESS_BITS)  out  to controller.
- mem_rd_ack  in  1; mem_rd_data  in  DATA_BITS.
- mem_wr_en, mem_wr_address (ADDRESS_BITS), mem_wr_data (DATA_BITS)  out  to controller.
- mem_wr_ack  in  1.

## Operation
- States: IDLE, ISSUE_RD, ISSUE_WR, WAIT_RD.
- IDLE, arbitration:
  - Pick the first p with req[p]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_PORTS.
  - Assert req_ack[p] combinationally in the same cycle.
  - On the clock edge: latch address, write data and we into cmd registers; latch grant = p; set rr_ptr ← (p+1) mod NUM_PORTS; go to ISSUE_WR if we, else ISSUE_RD.
  - No request: stay in IDLE; rr_ptr unchanged.
- Requester contract: hold req and the command stable until req_ack. Deassert req or present the next command on the edge after req_ack. Commands are captured at grant, so changes after that are ignored.
- ISSUE_WR:
  - mem_wr_en=1, driving the cmd registers.
  - Hold until mem_wr_ack=1, then go to IDLE.
  - Writes are posted; there is no completion indication.
- ISSUE_RD:
  - mem_rd_en=1.
  - Hold until mem_rd_ack=1, then go to WAIT_RD with lat_cnt ← 0.
- WAIT_RD:
  - lat_cnt increments each cycle.
  - When lat_cnt == RD_LATENCY-1: rd_data ← mem_rd_data, rd_valid ← onehot(grant) for one cycle, go to IDLE.
- Controller busy: mem_*_en stays high with no ack for any number of cycles. No timeout.
- mem_rd_en and mem_wr_en are never both high.
- lat_cnt width is $clog2(RD_LATENCY+1). PORT_BITS = max(1, $clog2(NUM_PORTS)).

## Timing
- Reset values: state=IDLE, rr_ptr=0, rd_valid=0, rd_data=0, busy=0, mem_rd_en=0, mem_wr_en=0, req_ack=0 while reset is high.
- Write, controller idle: grant at cycle t; ISSUE_WR at t+1 with mem_wr_ack the same cycle; IDLE at t+2. Next grant earliest at t+2.
- Read, controller idle: grant at t; mem_rd_ack at t+1; sample at t+1+RD_LATENCY; rd_valid high at t+2+RD_LATENCY, which is also the IDLE cycle. Default RD_LATENCY=3: rd_valid at t+5.
- rd_valid for one port and req_ack for a new grant may coincide in the same cycle. This is legal.
- A requester may re-request while its own read is outstanding. It cannot be granted until the arbiter returns to IDLE.
- Reset mid-operation:
  - Any in-flight read is abandoned, with no rd_valid.
  - mem_*_en drop the cycle after reset asserts.
  - The controller may still be finishing its cycle. The next issue simply waits for its ack; latency is counted from that ack, so no stale data is returned.

## Test plan
- Single write then read, port 1, RD_LATENCY=3, controller model acks immediately:
  - Write 0x12345 ← 0xBEEF: req_ack[1] at t, mem_wr_en at t+1.
  - Read 0x12345: rd_valid=0b0010 with rd_data=0xBEEF five cycles after its req_ack.
- Round-robin, all four ports requesting continuously with reads:
  - Grant order is 0, 1, 2, 3, 0.
  - rd_valid order matches; no port is granted twice before the others.
- Contention with pointer: rr_ptr=2, req=0b1011 → grant port 3, then 0, then 1.
- Back-pressure: controller withholds mem_rd_ack for 10 cycles.
  - mem_rd_en and mem_rd_address stay stable; busy=1.
  - No req_ack is issued to other requesting ports during that window.
- Read return overlapping a grant: port 0 read completes while port 2 requests.
  - rd_valid[0] and req_ack[2] are high in the same cycle.
  - Port 2's command is latched correctly.
- Reset during WAIT_RD, with lat_cnt=1:
  - rd_valid never pulses for the aborted read.
  - After reset, state=IDLE and rr_ptr=0.
  - A new read to port 0 completes with the correct data.
